// File: rtl/rr_grant_pkg.sv
// Shared types and defaults for the round-robin grant sequencer.
// Holds the controller state encoding and the default sizing constants.
package rr_grant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEFAULT_N_REQ    = 4;
  localparam int DEFAULT_HOLD_MAX = 8;
  localparam int DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: returns the first requester set
// after last_owner, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_owner,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  // The owner just served sits last in the search order, which gives fairness.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!pick_valid && req[(int'(last_owner) + i) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(last_owner) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter sharing one datapath between N_REQ requesters, with a
// bounded hold time and a gap cycle between owners. RR_GRANT_LOCK_EN adds a lock input.
module rr_grant_sequencer
  import rr_grant_pkg::*;
#(
  parameter int N_REQ    = DEFAULT_N_REQ,
  parameter int HOLD_MAX = DEFAULT_HOLD_MAX,
  parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef RR_GRANT_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             expired,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               expired_q, expired_d;
  logic               busy_q, busy_d;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               lock_hold;

`ifdef RR_GRANT_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Next-state logic; every output is computed here and registered below.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    expired_d    = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        if (pick_valid) begin
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          owner_d        = pick_id;
          hold_cnt_d     = '0;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        // A voluntary release takes precedence over a timeout on the same edge.
        if (!req[owner_q]) begin
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
          state_d    = GAP;
        end else if (lock_hold) begin
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else if (hold_cnt_q == HOLD_LAST) begin
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
          expired_d  = 1'b1;
          state_d    = GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        gnt_d        = '0;
        gnt_id_d     = '0;
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = IDLE;
      end
    endcase

    gnt_valid_d = |gnt_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      owner_q      <= '0;
      last_owner_q <= ID_W'(N_REQ - 1);
      hold_cnt_q   <= '0;
      expired_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_id_q     <= gnt_id_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      expired_q    <= expired_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign expired   = expired_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench for rr_grant_sequencer: directed scenarios plus random
// request traffic, compared every cycle against an ownership-level model.
module tb_rr_grant_sequencer;

  localparam int N   = 4;
  localparam int HM  = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           lockIn;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           expired;
  logic           busy;

  int checkCount = 0;
  int errCount   = 0;

  // Reference model: who owns the resource, for how many cycles, and how
  // many dead cycles remain before the next arbitration is allowed.
  int mOwner;
  int mHeld;
  int mCool;
  int mLast;
  bit mExp;

  always #5 clk = ~clk;

  rr_grant_sequencer #(
    .N_REQ    (N),
    .HOLD_MAX (HM),
    .ID_W     (IDW),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef RR_GRANT_LOCK_EN
    .lock      (lockIn),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .expired   (expired),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic releaseOwner();
    mLast  = mOwner;
    mOwner = -1;
    mCool  = 1;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled there.
  task automatic modelEdge();
    if (rst) begin
      mOwner = -1;
      mHeld  = 0;
      mCool  = 0;
      mLast  = N - 1;
      mExp   = 1'b0;
    end else begin
      mExp = 1'b0;
      if (mOwner >= 0) begin
        mHeld++;
        if (!req[mOwner]) begin
          releaseOwner();
        end else if (mHeld >= HM && !lockIn) begin
          releaseOwner();
          mExp = 1'b1;
        end
      end else if (mCool > 0) begin
        mCool--;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mLast + k) % N;
          if (mOwner < 0 && req[c]) begin
            mOwner = c;
            mHeld  = 0;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    logic [N-1:0] expGnt;
    expGnt = '0;
    if (mOwner >= 0) expGnt[mOwner] = 1'b1;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("gnt_valid", 32'(gnt_valid), 32'(mOwner >= 0));
    checkOutput("gnt_id", 32'(gnt_id), (mOwner >= 0) ? 32'(mOwner) : 32'd0);
    checkOutput("expired", 32'(expired), 32'(mExp));
    checkOutput("busy", 32'(busy), 32'((mOwner >= 0) || (mCool > 0)));
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic runCycles(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) applyStimulus(r, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
  endtask

  initial begin
    int expOrder[5];
    int seen[$];
    logic prevValid;
    logic [N-1:0] rBits;

    lockIn = 1'b0;
    req    = '0;
    rst    = 1'b1;
    expOrder = '{0, 1, 2, 3, 0};

    // Single requester: grant, timeout pulse, gap, re-grant.
    doReset();
    runCycles(4'b0001, 25);

    // All requesting: rotation order and spacing.
    doReset();
    prevValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(4'b1111, 1'b0);
      if (gnt_valid && !prevValid) seen.push_back(int'(gnt_id));
      prevValid = gnt_valid;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, 32'(expOrder[i]));
    end

    // Owner 2 drops early while 3 waits.
    doReset();
    runCycles(4'b1100, 3);
    runCycles(4'b1000, 15);

    // Reset in the middle of an ownership, then a lone request from 2.
    doReset();
    runCycles(4'b0001, 4);
    applyStimulus(4'b0001, 1'b1);
    runCycles(4'b0100, 6);

    // Request drop coinciding with the timeout edge.
    doReset();
    runCycles(4'b0001, 8);
    runCycles(4'b0000, 4);

    // Hold limit boundary with a second requester waiting.
    doReset();
    runCycles(4'b0011, 30);

`ifdef RR_GRANT_LOCK_EN
    doReset();
    lockIn = 1'b1;
    runCycles(4'b0010, 21);
    lockIn = 1'b0;
    runCycles(4'b0010, 5);
`endif

    // Random traffic with occasional resets.
    doReset();
    rBits = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rBits[b] = ~rBits[b];
      end
`ifdef RR_GRANT_LOCK_EN
      lockIn = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus(rBits, ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
